// File: rtl/tc_pkg.sv
// tc_pkg: dimensions, widths, FSM states and row-slicing helper for tc_core
package tc_pkg;
  localparam int M       = 16;
  localparam int N       = 16;
  localparam int K       = 16;
  localparam int TILE_M  = 4;
  localparam int TILE_N  = 4;
  localparam int TILE_K  = 4;
  localparam int DW_DATA = 16;
  localparam int DW_IDX  = 4;
  localparam int DW_MEM  = 256;
  typedef enum logic [1:0] {IDLE, COMPUTE, OUTPUT} state_t;
  function automatic logic [DW_DATA-1:0] elem(input logic [DW_MEM-1:0] row, input logic [DW_IDX-1:0] j);
    return row[j*DW_DATA +: DW_DATA];
  endfunction
endpackage

// File: rtl/tc_mac_tile.sv
// tc_mac_tile: combinational 4x4x4 dot-product plus accumulate for one tile; TC_SAT_ACC_EN selects signed saturation
module tc_mac_tile
  import tc_pkg::*;
(
  input  logic [DW_MEM-1:0] a_i,
  input  logic [DW_MEM-1:0] b_i,
  input  logic [DW_MEM-1:0] acc_i,
  output logic [DW_MEM-1:0] d_o
);
`ifdef TC_SAT_ACC_EN
  function automatic logic signed [35:0] sx(input logic [DW_DATA-1:0] v);
    return {{20{v[DW_DATA-1]}}, v};
  endfunction
  function automatic logic [DW_DATA-1:0] mac(input logic [63:0] a, input logic [63:0] b, input logic [DW_DATA-1:0] acc);
    logic signed [35:0] s;
    s = sx(acc);
    for (int k = 0; k < TILE_K; k++) s += sx(a[k*DW_DATA +: DW_DATA]) * sx(b[k*DW_DATA +: DW_DATA]);
    return s > 36'sd32767 ? 16'h7fff : s < -36'sd32768 ? 16'h8000 : s[DW_DATA-1:0];
  endfunction
`else
  function automatic logic [DW_DATA-1:0] mac(input logic [63:0] a, input logic [63:0] b, input logic [DW_DATA-1:0] acc);
    logic [DW_DATA-1:0] s;
    s = acc;
    for (int k = 0; k < TILE_K; k++) s += a[k*DW_DATA +: DW_DATA] * b[k*DW_DATA +: DW_DATA];
    return s;
  endfunction
`endif
  for (genvar i = 0; i < TILE_M; i++) begin : g_r
    for (genvar j = 0; j < TILE_N; j++) begin : g_c
      assign d_o[(i*TILE_N+j)*DW_DATA +: DW_DATA] = mac(
        a_i[i*TILE_K*DW_DATA +: TILE_K*DW_DATA],
        {b_i[(3*TILE_N+j)*DW_DATA +: DW_DATA], b_i[(2*TILE_N+j)*DW_DATA +: DW_DATA],
         b_i[(TILE_N+j)*DW_DATA +: DW_DATA], b_i[j*DW_DATA +: DW_DATA]},
        acc_i[(i*TILE_N+j)*DW_DATA +: DW_DATA]);
    end
  end
endmodule

// File: rtl/tc_core.sv
// tc_core: 16x16 D = A*B + C engine with tiled 4x4x4 MAC; TC_SAT_ACC_EN enables signed saturating accumulate
module tc_core
  import tc_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load_en,
  input  logic              compute_en,
  input  logic              write_a,
  input  logic [DW_MEM-1:0] A_input,
  input  logic [DW_IDX-1:0] A_row,
  input  logic              write_b,
  input  logic [DW_MEM-1:0] B_input,
  input  logic [DW_IDX-1:0] B_row,
  input  logic              write_c,
  input  logic [DW_MEM-1:0] C_input,
  input  logic [DW_IDX-1:0] C_row,
  output logic              out_valid,
  output logic [DW_MEM-1:0] D_row_out
);
  state_t state_q;
  logic [DW_MEM-1:0] a_q [M];
  logic [DW_MEM-1:0] b_q [K];
  logic [DW_MEM-1:0] c_q [M];
  logic [N*DW_DATA-1:0] d_q [M];
  logic [5:0] step_q;
  logic [DW_IDX-1:0] orow_q;
  logic [1:0] tm, tn, tk;
  logic [DW_MEM-1:0] a_t, b_t, acc_t, d_t;
  assign {tm, tn, tk} = step_q;
  // gather the A, B and accumulator tiles addressed by the current step (tk fastest, then tn, then tm)
  always_comb begin
    a_t = '0;
    b_t = '0;
    acc_t = '0;
    for (int i = 0; i < TILE_M; i++)
      for (int j = 0; j < TILE_N; j++) begin
        a_t[(i*TILE_N+j)*DW_DATA +: DW_DATA] = elem(a_q[{tm, 2'(i)}], {tk, 2'(j)});
        b_t[(i*TILE_N+j)*DW_DATA +: DW_DATA] = elem(b_q[{tk, 2'(i)}], {tn, 2'(j)});
        acc_t[(i*TILE_N+j)*DW_DATA +: DW_DATA] = elem(d_q[{tm, 2'(i)}], {tn, 2'(j)});
      end
  end
  tc_mac_tile u_mac (
    .a_i  (a_t),
    .b_i  (b_t),
    .acc_i(acc_t),
    .d_o  (d_t)
  );
  // load in IDLE, 64 tile steps in COMPUTE, 16 registered rows in OUTPUT
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      step_q <= '0;
      orow_q <= '0;
      out_valid <= 1'b0;
      D_row_out <= '0;
      for (int r = 0; r < M; r++) begin
        a_q[r] <= '0;
        b_q[r] <= '0;
        c_q[r] <= '0;
        d_q[r] <= '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          out_valid <= 1'b0;
          D_row_out <= '0;
          if (load_en) begin
            if (write_a) a_q[A_row] <= A_input;
            if (write_b) b_q[B_row] <= B_input;
            if (write_c) c_q[C_row] <= C_input;
          end else if (compute_en) begin
            for (int r = 0; r < M; r++) d_q[r] <= c_q[r];
            step_q <= '0;
            state_q <= COMPUTE;
          end
        end
        COMPUTE: begin
          for (int i = 0; i < TILE_M; i++)
            for (int j = 0; j < TILE_N; j++)
              d_q[{tm, 2'(i)}][{tn, 2'(j)}*DW_DATA +: DW_DATA] <= d_t[(i*TILE_N+j)*DW_DATA +: DW_DATA];
          step_q <= step_q + 6'd1;
          if (&step_q) begin
            orow_q <= '0;
            state_q <= OUTPUT;
          end
        end
        OUTPUT: begin
          out_valid <= 1'b1;
          D_row_out <= d_q[orow_q];
          orow_q <= orow_q + 1'b1;
          if (&orow_q) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_tc_core.sv
// tb_tc_core: randomized scoreboard bench for tc_core against a plain matrix-arithmetic model
module tb_tc_core;
  logic clk = 0, reset = 1, load_en = 0, compute_en = 0;
  logic write_a = 0, write_b = 0, write_c = 0;
  logic [255:0] A_input = '0, B_input = '0, C_input = '0;
  logic [3:0] A_row = '0, B_row = '0, C_row = '0;
  logic out_valid;
  logic [255:0] D_row_out;
  tc_core dut (
    .clk(clk), .reset(reset), .load_en(load_en), .compute_en(compute_en),
    .write_a(write_a), .A_input(A_input), .A_row(A_row),
    .write_b(write_b), .B_input(B_input), .B_row(B_row),
    .write_c(write_c), .C_input(C_input), .C_row(C_row),
    .out_valid(out_valid), .D_row_out(D_row_out)
  );
  always #5 clk = ~clk;
  int checks = 0, failures = 0, cyc = 0, rows_seen = 0;
  logic [15:0] ma [16][16], mb [16][16], mc [16][16];
  logic [255:0] exp_q [$];
  int cyc_q [$];
  always @(posedge clk) cyc++;
  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask
  function automatic logic [15:0] d_elem(input int i, input int j);
`ifdef TC_SAT_ACC_EN
    longint acc;
    acc = longint'($signed(mc[i][j]));
    for (int t = 0; t < 4; t++) begin
      for (int kk = 0; kk < 4; kk++)
        acc += longint'($signed(ma[i][t*4+kk])) * longint'($signed(mb[t*4+kk][j]));
      acc = acc > 32767 ? 32767 : acc < -32768 ? -32768 : acc;
    end
    return acc[15:0];
`else
    int acc;
    acc = int'(mc[i][j]);
    for (int k = 0; k < 16; k++) acc += int'(ma[i][k]) * int'(mb[k][j]);
    return acc[15:0];
`endif
  endfunction
  function automatic logic [255:0] pack(input logic [15:0] e [16]);
    logic [255:0] r;
    for (int j = 0; j < 16; j++) r[j*16 +: 16] = e[j];
    return r;
  endfunction
  // monitor: every valid row is popped and compared with data and arrival cycle
  always @(posedge clk) begin : mon
    logic [255:0] r;
    int c;
    #1;
    if (out_valid) begin
      if (exp_q.size() == 0) chk("spurious_valid", 256'(out_valid), 256'(0));
      else begin
        r = exp_q.pop_front();
        c = cyc_q.pop_front();
        chk("d_row", D_row_out, r);
        chk("row_cycle", 256'(cyc), 256'(c));
        rows_seen++;
      end
    end else chk("idle_zero", D_row_out, '0);
  end
  task automatic clear_model();
    for (int i = 0; i < 16; i++) for (int j = 0; j < 16; j++) begin
      ma[i][j] = '0; mb[i][j] = '0; mc[i][j] = '0;
    end
  endtask
  task automatic load_all();
    for (int r = 0; r < 16; r++) begin
      @(negedge clk);
      load_en = 1; write_a = 1; write_b = 1; write_c = 1;
      A_row = 4'(r); B_row = 4'(r); C_row = 4'(r);
      A_input = pack(ma[r]); B_input = pack(mb[r]); C_input = pack(mc[r]);
    end
    @(negedge clk);
    load_en = 0; write_a = 0; write_b = 0; write_c = 0;
  endtask
  task automatic start_compute();
    logic [15:0] e [16];
    @(negedge clk);
    compute_en = 1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) e[j] = d_elem(i, j);
      exp_q.push_back(pack(e));
      cyc_q.push_back(cyc + 65 + i);
    end
    @(negedge clk);
    compute_en = 0;
  endtask
  task automatic wait_done();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      chk("done_timeout", 256'(exp_q.size()), 256'(0));
      exp_q.delete();
      cyc_q.delete();
    end
    repeat (4) @(posedge clk);
  endtask
  task automatic run_case();
    load_all();
    start_compute();
    wait_done();
  endtask
  initial begin
    int n, base;
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", 256'(out_valid), 256'(0));
    chk("reset_row", D_row_out, '0);
    @(negedge clk);
    reset = 0;
    // identity: A=I, B=2, C=0
    for (int i = 0; i < 16; i++) for (int j = 0; j < 16; j++) begin
      ma[i][j] = (i == j) ? 16'd1 : 16'd0; mb[i][j] = 16'd2; mc[i][j] = 16'd0;
    end
    run_case();
    // accumulate: A=1, B=1, C=i*16+j
    for (int i = 0; i < 16; i++) for (int j = 0; j < 16; j++) begin
      ma[i][j] = 16'd1; mb[i][j] = 16'd1; mc[i][j] = 16'(i*16+j);
    end
    run_case();
    // wrap: 0x0100*0x0100 products, C=5
    for (int i = 0; i < 16; i++) for (int j = 0; j < 16; j++) begin
      ma[i][j] = 16'h0100; mb[i][j] = 16'h0100; mc[i][j] = 16'd5;
    end
    run_case();
    // large positive operands: saturates or wraps depending on build
    for (int i = 0; i < 16; i++) for (int j = 0; j < 16; j++) begin
      ma[i][j] = 16'h7fff; mb[i][j] = 16'd2; mc[i][j] = 16'd0;
    end
    run_case();
    // random matrices, with ignored loads and compute pulses during COMPUTE, then an identical repeat
    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < 16; i++) for (int j = 0; j < 16; j++) begin
        ma[i][j] = 16'($urandom); mb[i][j] = 16'($urandom); mc[i][j] = 16'($urandom);
      end
      load_all();
      start_compute();
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        load_en = 1; write_a = 1; write_b = 1; write_c = 1;
        A_row = 4'($urandom); B_row = 4'($urandom); C_row = 4'($urandom);
        A_input = {8{$urandom}}; B_input = {8{$urandom}}; C_input = {8{$urandom}};
        compute_en = 1'($urandom);
      end
      @(negedge clk);
      load_en = 0; write_a = 0; write_b = 0; write_c = 0; compute_en = 0;
      wait_done();
      start_compute();
      wait_done();
    end
    // load and compute in the same cycle: load wins, no run starts
    @(negedge clk);
    load_en = 1; write_c = 1; C_row = 4'd3; C_input = {8{$urandom}}; compute_en = 1;
    for (int j = 0; j < 16; j++) mc[3][j] = C_input[j*16 +: 16];
    @(negedge clk);
    load_en = 0; write_c = 0; compute_en = 0;
    repeat (90) @(posedge clk);
    start_compute();
    wait_done();
    // reset after row 5 of an output burst, then recompute from cleared matrices
    base = rows_seen;
    start_compute();
    n = 0;
    while (rows_seen < base + 6 && n < 200) begin
      @(posedge clk);
      n++;
    end
    chk("rows_before_reset", 256'(rows_seen - base), 256'(6));
    @(negedge clk);
    reset = 1;
    #1;
    chk("abort_valid", 256'(out_valid), 256'(0));
    chk("abort_row", D_row_out, '0);
    exp_q.delete();
    cyc_q.delete();
    clear_model();
    @(negedge clk);
    reset = 0;
    repeat (100) @(posedge clk);
    start_compute();
    wait_done();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/tc_core.md
Name: tc_core

Overview:
- Dense matrix multiply-accumulate core: D = A*B + C.
- A, B and C are 16x16 matrices of 16-bit elements.
- Operand rows are loaded one 256-bit row per cycle into internal register files. A compute_en pulse runs a tiled 4x4x4 MAC engine.
- Sits under the tensor-core controller; D rows stream back to the memory side.

Parameters:
- M, 16, rows of A/C/D
- N, 16, columns of B/C/D
- K, 16, inner dimension
- TILE_M, TILE_N, TILE_K, 4, tile dimensions
- DW_DATA, 16, element width
- DW_IDX, 4, row-index width
- DW_MEM, 256, row bus width (= 16*DW_DATA)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  reset
- load_en  in  1  global load enable
- compute_en  in  1  start pulse
- write_a  in  1  write A row
- A_input  in  DW_MEM  A row; element j at bits [j*16 +: 16]
- A_row  in  DW_IDX  A row index
- write_b  in  1  write B row
- B_input  in  DW_MEM  B row (row index = k)
- B_row  in  DW_IDX  B row index
- write_c  in  1  write C row
- C_input  in  DW_MEM  C row
- C_row  in  DW_IDX  C row index
- out_valid  out  1  D_row_out valid
- D_row_out  out  DW_MEM  D row; element n at bits [n*16 +: 16]

Interface rule: one clock; reset is asynchronous and active-high (ports named clk and reset).

Behaviour:
- Reset clears the A/B/C/D register files, returns the FSM to IDLE, and drives out_valid=0 and D_row_out=0. Reset mid-compute or mid-output aborts with no further out_valid.
- Loads, IDLE only:
  - On an edge with load_en=1 and write_x=1, row X_row of matrix x takes X_input.
  - A, B and C writes are independent and may occur in the same cycle.
  - Writes while not IDLE are ignored.
- FSM states: IDLE, COMPUTE, OUTPUT.
- IDLE -> COMPUTE on an edge sampling compute_en=1 with load_en=0. If load_en=1, load takes priority and compute_en is ignored.
- On entry to COMPUTE, the accumulator file D is initialised from C.
- COMPUTE runs 64 cycles. Each cycle updates one 4x4 output tile with one k-tile: D[tm*4+i][tn*4+j] += sum over kk of A[tm*4+i][tk*4+kk]*B[tk*4+kk][tn*4+j] (64 multiplies).
  - Order: tk innermost, then tn, then tm.
- OUTPUT runs 16 cycles. Rows 0..15 are emitted in order, one per cycle, with out_valid=1 on consecutive cycles.
  - The first row is valid 65 cycles after the edge that sampled compute_en; the last is valid after 80 cycles.
  - Then the FSM returns to IDLE with out_valid=0 and D_row_out holding 0.
- compute_en while COMPUTE or OUTPUT is ignored.
- Arithmetic: products and sums are taken modulo 2^16 (two's-complement wrap); there is no overflow flag.
- A/B/C contents persist after compute, so a repeated compute_en reproduces the same D.

Optional Feature:
- TC_SAT_ACC_EN defined: operands are signed; each tile-step sum is computed at full width, then D is clamped to [-32768, 32767].
- TC_SAT_ACC_EN undefined: modulo-2^16 wrap as above.

Decomposition:
- Package tc_pkg holds the dimension and tile constants, DW_* widths, the FSM state enum, and the row-slicing helper (element j of a row).
- One sub-module, tc_mac_tile: combinational 4x4x4 dot-product plus accumulator-add for one tile. Inputs are a 4x4 A tile, a 4x4 B tile and a 4x4 accumulator tile; output is the updated 4x4 tile. The saturation option is applied here.

Test Plan:
- Identity: A=I, B=all 0x0002, C=0 -> 16 consecutive out_valid rows, all elements 0x0002, in row order 0..15.
- Accumulate: A=all 1, B=all 1, C[i][j]=i*16+j -> D[i][j]=16+i*16+j; D[15][15]=271.
- Wrap: A=all 0x0100, B=all 0x0100, C=5 -> every element 0x0005 (products wrap to 0).
- Latency/handshake:
  - compute_en pulse -> out_valid first high 65 edges later and exactly 16 cycles long.
  - load_en/write_a pulses during COMPUTE do not alter the result.
  - A second compute_en gives identical D.
- Reset mid-OUTPUT (after row 5) -> out_valid drops immediately. A subsequent compute with no reload gives all zeros.
- TC_SAT_ACC_EN: A=all 0x7FFF, B=all 2, C=0 -> all D=0x7FFF. Without the macro -> 16*0xFFFE mod 2^16 = 0xFFE0.
